// File: rtl/mac8_sequencer.sv
// -----------------------------------------------------------------------------
// mac8_sequencer
//   Runs one matrix-vector job on the MAC8 datapath. The job steps through
//   loader handshake, accumulator clear, B-FIFO streaming with lane-skewed
//   A-FIFO pops, pipeline drain and completion. It also flags a stalled B
//   stream (timeout) and A-lane underflow.
//
// Optional feature (compile-time macro MAC8_SEQ_CYCLE_CNT_EN):
//   When defined, the block gains output cyc_cnt. This 16-bit counter counts
//   busy cycles, clears on an accepted go, saturates at 0xFFFF and holds its
//   value in DONE/ERR. When not defined, the port and counter do not exist.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   go         start-job pulse, accepted in IDLE, DONE and ERR
//   abort      return to IDLE from any state (highest priority)
//   ld_start   loader start request, high throughout LOAD
//   ld_done    loader finished filling the FIFOs
//   b_empty    B FIFO empty
//   b_rden     B FIFO pop (combinational from b_empty)
//   a_empty    A FIFO empty flags, one per lane
//   a_rden     A FIFO pops, one per lane
//   en_out     MAC8 per-lane pipelined enable
//   En_in      MAC8 enable injection (combinational, same as b_rden)
//   Clr_in     MAC8 accumulator clear
//   busy       job in progress (LOAD..DRAIN)
//   done       results valid in MAC8 accumulators
//   err        sticky error, equal to |err_code
//   err_code   bit0 B stall timeout, bit1 A underflow
//   state_dbg  encoded FSM state
//   issue_cnt  B elements issued this job
//   cyc_cnt    busy-cycle counter (MAC8_SEQ_CYCLE_CNT_EN only)
// -----------------------------------------------------------------------------
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for go
//   LOAD  | ld_start high, waiting for ld_done
//   CLEAR | one-cycle accumulator clear
//   EXEC  | stream B elements into the MAC8, one per non-empty cycle
//   DRAIN | let the lane pipeline empty (DRAIN cycles)
//   DONE  | results valid, waiting for the next go
//   ERR   | B stream stalled too long, waiting for go or abort
// -----------------------------------------------------------------------------
module mac8_sequencer #(
    parameter int N         = 8,
    parameter int VEC_LEN   = 8,
    parameter int DRAIN     = 9,
    parameter int STALL_MAX = 64,
    localparam int ICW      = $clog2(VEC_LEN + 1),
    localparam int DCW      = $clog2(DRAIN + 1),
    localparam int SCW      = $clog2(STALL_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic           abort,
    output logic           ld_start,
    input  logic           ld_done,
    input  logic           b_empty,
    output logic           b_rden,
    input  logic [N-1:0]   a_empty,
    output logic [N-1:0]   a_rden,
    input  logic [N-1:0]   en_out,
    output logic           En_in,
    output logic           Clr_in,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [1:0]     err_code,
    output logic [2:0]     state_dbg,
    output logic [ICW-1:0] issue_cnt
`ifdef MAC8_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]    cyc_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t         state;
    state_t         nxt;
    logic [DCW-1:0] drain_cnt;
    logic [SCW-1:0] stall_cnt;

    logic can_issue;
    logic issue;
    logic last_issue;
    logic stall;
    logic stall_to;
    logic lane_win;
    logic lane_fault;
    logic go_ok;

    // The combinational strobes are masked by reset and abort, so that no
    // pop or enable escapes in the cycle the job is being torn down.
    assign can_issue  = (issue_cnt < ICW'(VEC_LEN));
    assign issue      = rst_n && !abort && (state == S_EXEC) && !b_empty && can_issue;
    assign last_issue = (issue_cnt == ICW'(VEC_LEN - 1));
    assign stall      = (state == S_EXEC) && b_empty && can_issue;
    assign stall_to   = stall && (stall_cnt == SCW'(STALL_MAX - 1));
    assign lane_win   = rst_n && !abort && ((state == S_EXEC) || (state == S_DRAIN));
    assign lane_fault = lane_win && (|(en_out & a_empty));
    assign go_ok      = !abort && go &&
                        ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    assign En_in  = issue;
    assign b_rden = issue;
    assign a_rden = lane_win ? (en_out & ~a_empty) : '0;
    assign err    = |err_code;

    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (go) nxt = S_LOAD;
                S_LOAD:  if (ld_done) nxt = S_CLEAR;
                S_CLEAR: nxt = S_EXEC;
                S_EXEC: begin
                    if (!can_issue)
                        nxt = S_DRAIN;
                    else if (issue && last_issue)
                        nxt = S_DRAIN;
                    else if (stall_to)
                        nxt = S_ERR;
                end
                S_DRAIN: if (drain_cnt <= DCW'(1)) nxt = S_DONE;
                S_DONE:  if (go) nxt = S_LOAD;
                S_ERR:   if (go) nxt = S_LOAD;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // The Moore outputs are registered from the next state, so each one
    // changes on the same edge as the state it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ld_start  <= 1'b0;
            Clr_in    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_dbg <= 3'd0;
            issue_cnt <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            err_code  <= 2'b00;
        end else begin
            state     <= nxt;
            ld_start  <= (nxt == S_LOAD);
            Clr_in    <= (nxt == S_CLEAR);
            busy      <= (nxt == S_LOAD) || (nxt == S_CLEAR) ||
                         (nxt == S_EXEC) || (nxt == S_DRAIN);
            done      <= (nxt == S_DONE);
            state_dbg <= nxt;

            if (abort) begin
                issue_cnt <= '0;
                drain_cnt <= '0;
                stall_cnt <= '0;
                err_code  <= 2'b00;
            end else begin
                if (go_ok) begin
                    issue_cnt <= '0;
                    stall_cnt <= '0;
                    err_code  <= 2'b00;
                end

                if (issue) begin
                    issue_cnt <= issue_cnt + ICW'(1);
                    stall_cnt <= '0;
                end else if (stall) begin
                    stall_cnt <= stall_cnt + SCW'(1);
                end

                if (stall_to)
                    err_code[0] <= 1'b1;
                if (lane_fault)
                    err_code[1] <= 1'b1;

                if ((state != S_DRAIN) && (nxt == S_DRAIN))
                    drain_cnt <= DCW'(DRAIN);
                else if ((state == S_DRAIN) && (drain_cnt != '0))
                    drain_cnt <= drain_cnt - DCW'(1);
            end
        end
    end

`ifdef MAC8_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= 16'h0000;
        end else if (abort || go_ok) begin
            cyc_cnt <= 16'h0000;
        end else if (busy && (cyc_cnt != 16'hFFFF)) begin
            cyc_cnt <= cyc_cnt + 16'h0001;
        end
    end
`endif

endmodule
